// File: rtl/solitaire_pkg.sv
// Shared types and helpers for the peg-solitaire engine and its front end.
// Board geometry is the English 7x7 cross: a 3-wide horizontal arm and a
// 3-wide vertical arm, both spanning coordinates 2..4.
package solitaire_pkg;

    localparam int BOARD_SIZE = 7;

    typedef logic [2:0] coord_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    localparam coord_t COORD_MAX = coord_t'(BOARD_SIZE - 1);
    localparam coord_t ARM_LO    = 3'd2;
    localparam coord_t ARM_HI    = 3'd4;

    // True when (x, y) lies on the cross: inside the 7x7 square and inside
    // at least one of the two arms. Coordinate 7 always falls off the board.
    function automatic logic on_board(coord_t x, coord_t y);
        return (x <= COORD_MAX) && (y <= COORD_MAX) &&
               (((x >= ARM_LO) && (x <= ARM_HI)) ||
                ((y >= ARM_LO) && (y <= ARM_HI)));
    endfunction

endpackage

// File: rtl/solitaire_debounce.sv
// Level debouncer for an already-synchronised input. The output level only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples;
// rise pulses for one cycle, coincident with the 0->1 level change.
// DEBOUNCE_CYCLES is meaningful for 2..65535.
module solitaire_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic level_out,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count consecutive disagreeing samples; flip the level once the run is long enough.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_out <= 1'b0;
            cnt_q     <= '0;
            rise      <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (level_in == level_out) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_out <= level_in;
                cnt_q     <= '0;
                rise      <= level_in;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/solitaire_move_input.sv
// Move-entry front end for the solitaire engine: synchronises the raw pins,
// debounces the "go" button, captures one move per press and offers it to
// the engine over a valid/ready handshake.
// Build option: define SOLITAIRE_MOVE_VALIDATE_EN to reject off-board
// coordinates here (move_reject pulse); without it every press is forwarded
// and move_reject stays 0.
module solitaire_move_input
    import solitaire_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] piece_x_raw,
    input  logic [2:0] piece_y_raw,
    input  logic [1:0] direction_raw,
    input  logic       go_raw,
    output logic [2:0] move_x,
    output logic [2:0] move_y,
    output logic [1:0] move_dir,
    output logic       move_valid,
    input  logic       move_ready,
    output logic       move_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_RELEASE = 2'd2
    } move_state_t;

    localparam int SYNC_W = 9;

    logic [SYNC_W-1:0] raw_bus;
    logic [SYNC_W-1:0] sync_q1;
    logic [SYNC_W-1:0] sync_q2;

    coord_t      sync_x;
    coord_t      sync_y;
    dir_t        sync_dir;
    logic        sync_go;
    logic        go_level;
    logic        go_press;
    logic        press_legal;
    move_state_t state_q;

    assign raw_bus  = {go_raw, direction_raw, piece_y_raw, piece_x_raw};
    assign sync_x   = coord_t'(sync_q2[2:0]);
    assign sync_y   = coord_t'(sync_q2[5:3]);
    assign sync_dir = dir_t'(sync_q2[7:6]);
    assign sync_go  = sync_q2[8];

    // Two-flop synchroniser for every asynchronous input pin.
    // NOTE: synchroniser flops are reset so a held button looks like a fresh edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_bus;
            sync_q2 <= sync_q1;
        end
    end

    solitaire_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk      (clk),
        .rst      (rst),
        .level_in (sync_go),
        .level_out(go_level),
        .rise     (go_press)
    );

`ifdef SOLITAIRE_MOVE_VALIDATE_EN
    assign press_legal = on_board(sync_x, sync_y);
`else
    assign press_legal = 1'b1;
`endif

    // Capture/handshake FSM with registered outputs; one move outstanding at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            move_x      <= '0;
            move_y      <= '0;
            move_dir    <= '0;
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_press) begin
                        move_x   <= sync_x;
                        move_y   <= sync_y;
                        move_dir <= sync_dir;
                        busy     <= 1'b1;
                        if (press_legal) begin
                            state_q    <= S_PENDING;
                            move_valid <= 1'b1;
                        end else begin
                            state_q     <= S_RELEASE;
                            move_reject <= 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    // Payload registers are untouched here, so it stays stable while valid.
                    if (move_valid && move_ready) begin
                        move_valid <= 1'b0;
                        state_q    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!go_level) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    move_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solitaire_move_input.sv
// Directed bench for solitaire_move_input with DEBOUNCE_CYCLES = 4.
// Expectations for off-board presses follow whether
// SOLITAIRE_MOVE_VALIDATE_EN is defined for this build.
module tb_solitaire_move_input;

`ifdef SOLITAIRE_MOVE_VALIDATE_EN
    localparam bit VALIDATE = 1'b1;
`else
    localparam bit VALIDATE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] piece_x_raw;
    logic [2:0] piece_y_raw;
    logic [1:0] direction_raw;
    logic       go_raw;
    logic [2:0] move_x;
    logic [2:0] move_y;
    logic [1:0] move_dir;
    logic       move_valid;
    logic       move_ready;
    logic       move_reject;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    solitaire_move_input #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .piece_x_raw  (piece_x_raw),
        .piece_y_raw  (piece_y_raw),
        .direction_raw(direction_raw),
        .go_raw       (go_raw),
        .move_x       (move_x),
        .move_y       (move_y),
        .move_dir     (move_dir),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .move_reject  (move_reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_pins(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d);
        piece_x_raw   = x;
        piece_y_raw   = y;
        direction_raw = d;
    endtask

    // Release the button and wait (bounded) for busy to drop; no move may appear meanwhile.
    task automatic release_and_idle(input string tag);
        int n     = 0;
        int extra = 0;
        go_raw = 1'b0;
        while (busy === 1'b1 && n < 30) begin
            step();
            n++;
            if (move_valid === 1'b1) extra++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_no_extra_move"}, extra, 0);
        steps(3);
    endtask

    // Clean press with move_ready held high; legal is the hand-computed on-board result.
    task automatic do_press(input string tag, input logic [2:0] x, input logic [2:0] y,
                            input logic [1:0] d, input bit legal);
        bit exp_valid;
        bit exp_reject;
        exp_valid  = legal || !VALIDATE;
        exp_reject = !legal && VALIDATE;
        set_pins(x, y, d);
        move_ready = 1'b1;
        go_raw     = 1'b1;
        steps(6);
        check({tag, "_early_valid"}, move_valid, 1'b0);
        step();
        check({tag, "_valid"}, move_valid, exp_valid);
        check({tag, "_reject"}, move_reject, exp_reject);
        check({tag, "_payload"}, {move_dir, move_y, move_x}, {d, y, x});
        step();
        check({tag, "_valid_after"}, move_valid, 1'b0);
        check({tag, "_reject_after"}, move_reject, 1'b0);
        check({tag, "_busy_release"}, busy, 1'b1);
        release_and_idle(tag);
    endtask

    logic [2:0] bx [7] = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd7, 3'd5, 3'd0};
    logic [2:0] by [7] = '{3'd0, 3'd6, 3'd2, 3'd1, 3'd3, 3'd5, 3'd0};
    bit         bl [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst        = 1'b1;
        go_raw     = 1'b0;
        move_ready = 1'b0;
        set_pins(3'd0, 3'd0, 2'd0);

        // Reset state
        steps(2);
        check("rst_valid", move_valid, 1'b0);
        check("rst_reject", move_reject, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_payload", {move_dir, move_y, move_x}, 8'h00);
        rst = 1'b0;
        steps(3);

        // Clean press (3,1,S), ready high: valid exactly 7 cycles after the rise
        set_pins(3'd3, 3'd1, 2'd2);
        move_ready = 1'b1;
        go_raw     = 1'b1;
        steps(6);
        check("clean_valid_c6", move_valid, 1'b0);
        check("clean_busy_c6", busy, 1'b0);
        step();
        check("clean_valid_c7", move_valid, 1'b1);
        check("clean_payload", {move_dir, move_y, move_x}, {2'd2, 3'd1, 3'd3});
        check("clean_busy_c7", busy, 1'b1);
        step();
        check("clean_valid_c8", move_valid, 1'b0);
        go_raw = 1'b0;
        steps(6);
        check("clean_busy_hold", busy, 1'b1);
        step();
        check("clean_busy_drop", busy, 1'b0);
        steps(3);

        // Bounce: 1/0/1/0 then stable 1; one move timed from the last rise
        set_pins(3'd2, 3'd3, 2'd1);
        go_raw = 1'b1; step();
        go_raw = 1'b0; step();
        go_raw = 1'b1; step();
        go_raw = 1'b0; step();
        check("bounce_no_valid", move_valid, 1'b0);
        go_raw = 1'b1;
        steps(6);
        check("bounce_valid_c6", move_valid, 1'b0);
        step();
        check("bounce_valid_c7", move_valid, 1'b1);
        check("bounce_payload", {move_dir, move_y, move_x}, {2'd1, 3'd3, 3'd2});
        steps(8);
        release_and_idle("bounce");

        // Backpressure: payload frozen, second press ignored, transfer on first ready
        set_pins(3'd4, 3'd4, 2'd1);
        move_ready = 1'b0;
        go_raw     = 1'b1;
        steps(7);
        check("bp_valid", move_valid, 1'b1);
        set_pins(3'd0, 3'd7, 2'd3);
        go_raw = 1'b0;
        steps(10);
        check("bp_valid_10", move_valid, 1'b1);
        check("bp_payload_10", {move_dir, move_y, move_x}, {2'd1, 3'd4, 3'd4});
        go_raw = 1'b1;
        steps(12);
        check("bp_valid_22", move_valid, 1'b1);
        check("bp_payload_22", {move_dir, move_y, move_x}, {2'd1, 3'd4, 3'd4});
        move_ready = 1'b1;
        step();
        check("bp_transfer", move_valid, 1'b0);
        check("bp_busy", busy, 1'b1);
        steps(5);
        check("bp_no_second", move_valid, 1'b0);
        release_and_idle("bp");

        // Reset while PENDING with the button held
        set_pins(3'd3, 3'd3, 2'd0);
        move_ready = 1'b0;
        go_raw     = 1'b1;
        steps(7);
        check("rp_valid", move_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rp_async_valid", move_valid, 1'b0);
        check("rp_async_busy", busy, 1'b0);
        check("rp_async_payload", {move_dir, move_y, move_x}, 8'h00);
        move_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        steps(6);
        check("rp_valid_c6", move_valid, 1'b0);
        step();
        check("rp_valid_c7", move_valid, 1'b1);
        check("rp_payload", {move_dir, move_y, move_x}, {2'd0, 3'd3, 3'd3});
        step();
        check("rp_valid_c8", move_valid, 1'b0);
        release_and_idle("rp");

        // Boundary coordinates and the off-board origin
        for (int i = 0; i < 7; i++) begin
            do_press($sformatf("bnd%0d", i), bx[i], by[i], 2'(i), bl[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
